// File: rtl/iobus_pkg.sv
// Shared constants for the IOBUS responder: register word offsets, timer CTRL
// field positions and the timer run-state encoding.
package iobus_pkg;

    // Word offsets, i.e. IOBUS_ADDR[6:2] of each register in the 128-byte window.
    localparam logic [4:0] OFS_SW    = 5'h00;  // 0x00
    localparam logic [4:0] OFS_LED   = 5'h08;  // 0x20
    localparam logic [4:0] OFS_SSEG  = 5'h10;  // 0x40
    localparam logic [4:0] OFS_TCNT  = 5'h18;  // 0x60
    localparam logic [4:0] OFS_TCMP  = 5'h19;  // 0x64
    localparam logic [4:0] OFS_TCTRL = 5'h1A;  // 0x68
    localparam logic [4:0] OFS_TSTAT = 5'h1B;  // 0x6C

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_PRESC_LSB  = 16;
    localparam int CTRL_PRESC_MSB  = 31;
    localparam int STAT_FLAG_BIT   = 0;

    typedef enum logic {
        TMR_STOP = 1'b0,
        TMR_RUN  = 1'b1
    } tmr_state_e;

endpackage

// File: rtl/iobus_if.sv
// Core-side IOBUS: registered address/data/strobe from the memory stage and
// the registered read data returned by the responder.
interface iobus_if;

    logic        iobus_wr;
    logic [31:0] iobus_addr;
    logic [31:0] iobus_out;
    logic [31:0] iobus_in;

    modport master (
        output iobus_wr,
        output iobus_addr,
        output iobus_out,
        input  iobus_in
    );

    modport slave (
        input  iobus_wr,
        input  iobus_addr,
        input  iobus_out,
        output iobus_in
    );

endinterface

// File: rtl/iobus_timer.sv
// Prescaled compare timer: COUNT advances every PRESCALE+1 cycles while running,
// reloads to 0 on reaching COMPARE and sets a sticky, write-1-to-clear FLAG.
module iobus_timer
    import iobus_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_i,      // decoded write strobe (window hit already applied)
    input  logic [4:0]  ofs_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    tmr_state_e  state_q, state_d;
    logic [15:0] presc_q, presc_d;
    logic [15:0] presc_lim_q, presc_lim_d;
    logic        irq_en_q, irq_en_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        flag_q, flag_d;

    logic cnt_wr, cmp_wr, ctrl_wr, stat_wr;
    logic tick, match;

    assign cnt_wr  = wr_i && (ofs_i == OFS_TCNT);
    assign cmp_wr  = wr_i && (ofs_i == OFS_TCMP);
    assign ctrl_wr = wr_i && (ofs_i == OFS_TCTRL);
    assign stat_wr = wr_i && (ofs_i == OFS_TSTAT);

    assign tick  = (state_q == TMR_RUN) && (presc_q == presc_lim_q);
    assign match = tick && (count_q == compare_q);

    // NOTE: every output of a combinational block gets a default first, otherwise
    // any path that skips an assignment infers a latch.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        presc_lim_d = presc_lim_q;
        irq_en_d    = irq_en_q;
        count_d     = count_q;
        compare_d   = compare_q;
        flag_d      = flag_q;

        case (state_q)
            TMR_STOP: begin
                if (ctrl_wr && wdata_i[CTRL_EN_BIT]) begin
                    state_d = TMR_RUN;
                    presc_d = '0;
                end
            end
            TMR_RUN: begin
                presc_d = tick ? '0 : presc_q + 16'd1;
                if (match) begin
                    count_d = '0;
                end else if (tick) begin
                    count_d = count_q + 32'd1;
                end
                if (ctrl_wr && !wdata_i[CTRL_EN_BIT]) begin
                    state_d = TMR_STOP;
                end
            end
            default: state_d = TMR_STOP;
        endcase

        // A software COUNT write overrides any tick on the same edge and restarts the prescaler.
        if (cnt_wr) begin
            count_d = wdata_i;
            presc_d = '0;
        end
        if (cmp_wr) begin
            compare_d = wdata_i;
        end
        if (ctrl_wr) begin
            irq_en_d    = wdata_i[CTRL_IRQ_EN_BIT];
            presc_lim_d = wdata_i[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
        end

        // Set has priority over a simultaneous write-1-to-clear.
        if (stat_wr && wdata_i[STAT_FLAG_BIT]) begin
            flag_d = 1'b0;
        end
        if (match && !cnt_wr) begin
            flag_d = 1'b1;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= TMR_STOP;
            presc_q     <= '0;
            presc_lim_q <= '0;
            irq_en_q    <= 1'b0;
            count_q     <= '0;
            compare_q   <= '1;
            flag_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            presc_lim_q <= presc_lim_d;
            irq_en_q    <= irq_en_d;
            count_q     <= count_d;
            compare_q   <= compare_d;
            flag_q      <= flag_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (ofs_i)
            OFS_TCNT:  rdata_o = count_q;
            OFS_TCMP:  rdata_o = compare_q;
            OFS_TCTRL: rdata_o = {presc_lim_q, 14'b0, irq_en_q, (state_q == TMR_RUN)};
            OFS_TSTAT: rdata_o = {31'b0, flag_q};
            default:   rdata_o = '0;
        endcase
    end

    assign irq_o = flag_q & irq_en_q;

endmodule

// File: rtl/iobus_responder.sv
// Memory-mapped I/O responder: LED/seven-segment registers, synchronized switches
// and, when IOBUS_TIMER_EN is defined, a prescaled compare timer with interrupt.
module iobus_responder
    import iobus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0000,
    parameter int          SW_WIDTH  = 16,
    parameter int          LED_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    iobus_if.slave               bus,
    input  logic [SW_WIDTH-1:0]  switches_i,
    output logic [LED_WIDTH-1:0] leds_o,
    output logic [15:0]          sseg_data_o,
    output logic                 timer_irq_o
);

    logic                 hit;
    logic                 wr_hit;
    logic [4:0]           ofs;
    logic [SW_WIDTH-1:0]  sw_meta_q, sw_sync_q;
    logic [LED_WIDTH-1:0] leds_q, leds_d;
    logic [15:0]          sseg_q, sseg_d;
    logic [31:0]          iobus_in_q, iobus_in_d;
    logic [31:0]          tmr_rdata;
    logic                 tmr_irq;

    assign hit    = (bus.iobus_addr[31:7] == BASE_ADDR[31:7]);
    assign ofs    = bus.iobus_addr[6:2];
    assign wr_hit = hit && bus.iobus_wr;

    // Byte-lane bits and the upper write-data half have no consumer in every build.
    logic unused_bits;
    assign unused_bits = ^{bus.iobus_addr[1:0], bus.iobus_out[31:16]};

`ifdef IOBUS_TIMER_EN
    iobus_timer u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_i    (wr_hit),
        .ofs_i   (ofs),
        .wdata_i (bus.iobus_out),
        .rdata_o (tmr_rdata),
        .irq_o   (tmr_irq)
    );
`else
    assign tmr_rdata = '0;
    assign tmr_irq   = 1'b0;
`endif

    always_comb begin
        leds_d = leds_q;
        sseg_d = sseg_q;
        if (wr_hit && (ofs == OFS_LED)) begin
            leds_d = bus.iobus_out[LED_WIDTH-1:0];
        end
        if (wr_hit && (ofs == OFS_SSEG)) begin
            sseg_d = bus.iobus_out[15:0];
        end
    end

    // Read mux sees pre-edge register values, so a same-cycle write reads back old data.
    always_comb begin
        iobus_in_d = '0;
        if (hit) begin
            case (ofs)
                OFS_SW:    iobus_in_d = 32'(sw_sync_q);
                OFS_LED:   iobus_in_d = 32'(leds_q);
                OFS_SSEG:  iobus_in_d = {16'b0, sseg_q};
                OFS_TCNT,
                OFS_TCMP,
                OFS_TCTRL,
                OFS_TSTAT: iobus_in_d = tmr_rdata;
                default:   iobus_in_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            leds_q     <= '0;
            sseg_q     <= '0;
            iobus_in_q <= '0;
        end else begin
            sw_meta_q  <= switches_i;
            sw_sync_q  <= sw_meta_q;
            leds_q     <= leds_d;
            sseg_q     <= sseg_d;
            iobus_in_q <= iobus_in_d;
        end
    end

    assign bus.iobus_in = iobus_in_q;
    assign leds_o       = leds_q;
    assign sseg_data_o  = sseg_q;
    assign timer_irq_o  = tmr_irq;

endmodule
